// File: rtl/if_stage_pkg.sv
// Bus types shared between pre_IF, IF and ID for the instruction-fetch path.
package if_stage_pkg;

    typedef struct packed {
        logic       ex;
        logic [4:0] exccode;
    } exception_t;

    typedef struct packed {
        logic        valid;
        logic        req;
        logic        br_op;
        logic [31:0] pc;
        exception_t  exception;
    } pfs_to_fs_bus_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        br_op;
        exception_t  exception;
    } fs_to_ds_bus_t;

endpackage

// File: rtl/if_stage.sv
// IF stage: waits in order for ICache read data, buffers it across ID stalls,
// and drops responses that belong to fetches cancelled by a pipeline flush.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int CNT_WIDTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  pfs_to_fs_bus_t pfs_to_fs_bus,
    output logic           fs_allowin,
    input  logic           pfs_outstanding,
    input  logic           ds_allowin,
    output fs_to_ds_bus_t  fs_to_ds_bus,
    input  logic           flush,
    input  logic           icache_data_ok,
    input  logic [31:0]    icache_rdata,
    output logic           fs_discarding
);

    localparam int SUM_WIDTH = CNT_WIDTH + 2;
    localparam logic [SUM_WIDTH-1:0] CNT_MAX = SUM_WIDTH'((1 << CNT_WIDTH) - 1);

    typedef struct packed {
        logic        req;
        logic        br_op;
        logic [31:0] pc;
        exception_t  exception;
    } fs_entry_t;

    logic                 fs_valid;
    fs_entry_t            fs_bus;
    logic [31:0]          inst_buf;
    logic                 inst_buf_valid;
    logic [CNT_WIDTH-1:0] discard_cnt;

    logic                 discard_active;
    logic                 data_ok_live;
    logic                 discard_dec;
    logic                 fs_waiting;
    logic                 fs_ready_go;
    logic                 lost_on_flush;
    logic [SUM_WIDTH-1:0] discard_sum;

    // While stale responses are outstanding, every data_ok belongs to a cancelled fetch.
    assign discard_active = (discard_cnt != '0);
    assign data_ok_live   = icache_data_ok && !discard_active;
    assign discard_dec    = icache_data_ok && discard_active;

    assign fs_waiting  = fs_valid && fs_bus.req && !fs_bus.exception.ex && !inst_buf_valid;
    assign fs_ready_go = !fs_waiting || data_ok_live;
    assign fs_allowin  = flush || !fs_valid || (fs_ready_go && ds_allowin);

    assign fs_discarding = discard_active;

    // A fetch still waiting when the flush hits leaves one response in flight,
    // unless that response is arriving in this very cycle.
    assign lost_on_flush = flush && fs_waiting && !data_ok_live;

    assign discard_sum = SUM_WIDTH'(discard_cnt)
                       - SUM_WIDTH'(discard_dec)
                       + SUM_WIDTH'(lost_on_flush)
                       + SUM_WIDTH'(flush && pfs_outstanding);

    always_comb begin
        fs_to_ds_bus           = '0;
        fs_to_ds_bus.valid     = fs_valid && fs_ready_go && !flush;
        fs_to_ds_bus.pc        = fs_bus.pc;
        fs_to_ds_bus.br_op     = fs_bus.br_op;
        fs_to_ds_bus.exception = fs_bus.exception;
        if (inst_buf_valid) begin
            fs_to_ds_bus.inst = inst_buf;
        end else if (fs_bus.exception.ex || !fs_bus.req) begin
            fs_to_ds_bus.inst = 32'h0;
        end else begin
            fs_to_ds_bus.inst = icache_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid       <= 1'b0;
            fs_bus         <= '0;
            inst_buf       <= '0;
            inst_buf_valid <= 1'b0;
        end else if (flush) begin
            fs_valid       <= 1'b0;
            inst_buf_valid <= 1'b0;
        end else if (fs_allowin) begin
            fs_valid         <= pfs_to_fs_bus.valid;
            fs_bus.req       <= pfs_to_fs_bus.req;
            fs_bus.br_op     <= pfs_to_fs_bus.br_op;
            fs_bus.pc        <= pfs_to_fs_bus.pc;
            fs_bus.exception <= pfs_to_fs_bus.exception;
            inst_buf_valid   <= 1'b0;
        end else if (fs_waiting && data_ok_live && !ds_allowin) begin
            inst_buf       <= icache_rdata;
            inst_buf_valid <= 1'b1;
        end
    end

    // The ICache is reset alongside this stage, so reset drops any pending discards.
    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= '0;
        end else begin
            discard_cnt <= discard_sum[CNT_WIDTH-1:0];
        end
    end

    discard_cnt_no_overflow: assert property (
        @(posedge clk) disable iff (reset) discard_sum <= CNT_MAX
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage; a scoreboard checks every instruction handed to ID.
module tb_if_stage;
    import if_stage_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    pfs_to_fs_bus_t pfs_to_fs_bus;
    logic           fs_allowin;
    logic           pfs_outstanding;
    logic           ds_allowin;
    fs_to_ds_bus_t  fs_to_ds_bus;
    logic           flush;
    logic           icache_data_ok;
    logic [31:0]    icache_rdata;
    logic           fs_discarding;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        ex;
        logic [4:0]  exccode;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    if_stage #(.CNT_WIDTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .pfs_to_fs_bus   (pfs_to_fs_bus),
        .fs_allowin      (fs_allowin),
        .pfs_outstanding (pfs_outstanding),
        .ds_allowin      (ds_allowin),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .flush           (flush),
        .icache_data_ok  (icache_data_ok),
        .icache_rdata    (icache_rdata),
        .fs_discarding   (fs_discarding)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic apply_stimulus(input logic valid, input logic req, input logic [31:0] pc,
                                  input logic ex, input logic [4:0] exccode);
        pfs_to_fs_bus.valid             = valid;
        pfs_to_fs_bus.req               = req;
        pfs_to_fs_bus.br_op             = 1'b0;
        pfs_to_fs_bus.pc                = pc;
        pfs_to_fs_bus.exception.ex      = ex;
        pfs_to_fs_bus.exception.exccode = exccode;
    endtask

    task automatic expect_out(input logic [31:0] inst, input logic [31:0] pc,
                              input logic ex, input logic [4:0] exccode);
        exp_t e;
        e.inst    = inst;
        e.pc      = pc;
        e.ex      = ex;
        e.exccode = exccode;
        exp_q.push_back(e);
    endtask

    // Monitor: every ID handshake must match the oldest expected instruction.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (!reset && fs_to_ds_bus.valid && ds_allowin) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_output: got inst 0x%08h pc 0x%08h, expected no transfer",
                             fs_to_ds_bus.inst, fs_to_ds_bus.pc);
                end else begin
                    e = exp_q.pop_front();
                    check_output("id_inst", fs_to_ds_bus.inst, e.inst);
                    check_output("id_pc", fs_to_ds_bus.pc, e.pc);
                    check_output("id_ex", {31'b0, fs_to_ds_bus.exception.ex}, {31'b0, e.ex});
                    check_output("id_exccode", {27'b0, fs_to_ds_bus.exception.exccode},
                                 {27'b0, e.exccode});
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        pfs_outstanding = 1'b0;
        ds_allowin      = 1'b1;
        flush           = 1'b0;
        icache_data_ok  = 1'b0;
        icache_rdata    = 32'h0;
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'h0);
        repeat (3) step();
        reset = 1'b0;
        settle();
        check_output("reset_valid", {31'b0, fs_to_ds_bus.valid}, 32'd0);
        check_output("reset_allowin", {31'b0, fs_allowin}, 32'd1);
        check_output("reset_discarding", {31'b0, fs_discarding}, 32'd0);

        // Normal fetch with zero-latency bypass.
        apply_stimulus(1'b1, 1'b1, 32'hBFC00000, 1'b0, 5'h0);
        step();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'h0);
        icache_data_ok = 1'b1;
        icache_rdata   = 32'h24080001;
        expect_out(32'h24080001, 32'hBFC00000, 1'b0, 5'h0);
        settle();
        check_output("t1_allowin", {31'b0, fs_allowin}, 32'd1);
        step();
        icache_data_ok = 1'b0;

        // ID stall: data is buffered and held for three cycles.
        apply_stimulus(1'b1, 1'b1, 32'hBFC00004, 1'b0, 5'h0);
        step();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'h0);
        icache_data_ok = 1'b1;
        icache_rdata   = 32'h3C1DBFC0;
        ds_allowin     = 1'b0;
        settle();
        check_output("t2_valid_c0", {31'b0, fs_to_ds_bus.valid}, 32'd1);
        check_output("t2_allowin_c0", {31'b0, fs_allowin}, 32'd0);
        check_output("t2_inst_c0", fs_to_ds_bus.inst, 32'h3C1DBFC0);
        for (int i = 1; i < 3; i++) begin
            step();
            icache_data_ok = 1'b0;
            icache_rdata   = 32'hDEADBEEF;
            settle();
            check_output("t2_valid_held", {31'b0, fs_to_ds_bus.valid}, 32'd1);
            check_output("t2_inst_held", fs_to_ds_bus.inst, 32'h3C1DBFC0);
            check_output("t2_allowin_held", {31'b0, fs_allowin}, 32'd0);
        end
        step();
        ds_allowin = 1'b1;
        apply_stimulus(1'b1, 1'b1, 32'hBFC00008, 1'b0, 5'h0);
        expect_out(32'h3C1DBFC0, 32'hBFC00004, 1'b0, 5'h0);
        settle();
        check_output("t2_allowin_release", {31'b0, fs_allowin}, 32'd1);
        step();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'h0);

        // Flush while waiting on BFC00008 with one more request in pre_IF.
        pfs_outstanding = 1'b1;
        flush           = 1'b1;
        settle();
        check_output("t3_valid_flush", {31'b0, fs_to_ds_bus.valid}, 32'd0);
        step();
        flush           = 1'b0;
        pfs_outstanding = 1'b0;
        settle();
        check_output("t3_discarding", {31'b0, fs_discarding}, 32'd1);
        apply_stimulus(1'b1, 1'b1, 32'hBFC00380, 1'b0, 5'h0);
        step();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'h0);
        icache_data_ok = 1'b1;
        icache_rdata   = 32'h11111111;
        settle();
        check_output("t3_drop1_valid", {31'b0, fs_to_ds_bus.valid}, 32'd0);
        check_output("t3_drop1_discarding", {31'b0, fs_discarding}, 32'd1);
        step();
        icache_rdata = 32'h22222222;
        settle();
        check_output("t3_drop2_valid", {31'b0, fs_to_ds_bus.valid}, 32'd0);
        check_output("t3_drop2_discarding", {31'b0, fs_discarding}, 32'd1);
        step();
        icache_rdata = 32'h33333333;
        expect_out(32'h33333333, 32'hBFC00380, 1'b0, 5'h0);
        settle();
        check_output("t3_discard_done", {31'b0, fs_discarding}, 32'd0);
        step();
        icache_data_ok = 1'b0;

        // Flush in the same cycle as the waiting fetch's data_ok.
        apply_stimulus(1'b1, 1'b1, 32'hBFC00390, 1'b0, 5'h0);
        step();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'h0);
        icache_data_ok = 1'b1;
        icache_rdata   = 32'h44444444;
        flush          = 1'b1;
        settle();
        check_output("t4_valid_flush", {31'b0, fs_to_ds_bus.valid}, 32'd0);
        step();
        flush          = 1'b0;
        icache_data_ok = 1'b0;
        settle();
        check_output("t4_no_discard", {31'b0, fs_discarding}, 32'd0);
        apply_stimulus(1'b1, 1'b1, 32'hBFC003A0, 1'b0, 5'h0);
        step();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'h0);
        icache_data_ok = 1'b1;
        icache_rdata   = 32'h55555555;
        expect_out(32'h55555555, 32'hBFC003A0, 1'b0, 5'h0);
        step();
        icache_data_ok = 1'b0;

        // Fetch exception: ready at once, no ICache data used.
        apply_stimulus(1'b1, 1'b0, 32'h00000001, 1'b1, 5'h04);
        step();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'h0);
        icache_rdata = 32'h66666666;
        expect_out(32'h0, 32'h00000001, 1'b1, 5'h04);
        settle();
        check_output("t5_valid", {31'b0, fs_to_ds_bus.valid}, 32'd1);
        step();

        // Reset while waiting with one pending discard.
        apply_stimulus(1'b1, 1'b1, 32'hBFC00400, 1'b0, 5'h0);
        step();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        settle();
        check_output("t6_discarding_before", {31'b0, fs_discarding}, 32'd1);
        apply_stimulus(1'b1, 1'b1, 32'hBFC00410, 1'b0, 5'h0);
        step();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        check_output("t6_valid", {31'b0, fs_to_ds_bus.valid}, 32'd0);
        check_output("t6_allowin", {31'b0, fs_allowin}, 32'd1);
        check_output("t6_discarding", {31'b0, fs_discarding}, 32'd0);
        apply_stimulus(1'b1, 1'b1, 32'hBFC00420, 1'b0, 5'h0);
        step();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'h0);
        icache_data_ok = 1'b1;
        icache_rdata   = 32'h77777777;
        expect_out(32'h77777777, 32'hBFC00420, 1'b0, 5'h0);
        step();
        icache_data_ok = 1'b0;

        repeat (3) step();
        check_output("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5+ stage MIPS pipeline, between pre_IF and ID.
- Accepts fetch requests already issued to the ICache by pre_IF (pfs_to_fs_bus_t) and waits in order for the ICache response.
- Holds the returned instruction when ID stalls, then presents it to ID as fs_to_ds_bus_t.
- On a pipeline flush, tracks and discards ICache responses that belong to cancelled fetches.

Parameters:
- CNT_WIDTH, 2, width of the discard counter; at most 3 cancelled responses can be outstanding.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- pfs_to_fs_bus  input  pfs_to_fs_bus_t  fetch from pre_IF: valid, req (ICache addr_ok already received), br_op, pc, exception.
- fs_allowin  output  1  IF can accept pfs_to_fs_bus this cycle.
- pfs_outstanding  input  1  pre_IF holds an addr-accepted request not yet passed to IF.
- ds_allowin  input  1  ID can accept this cycle.
- fs_to_ds_bus  output  fs_to_ds_bus_t  valid, inst, pc, exception to ID.
- flush  input  1  OR of pipeline_flush_t fields from WB.
- icache_data_ok  input  1  ICache read data valid; responses arrive in request order.
- icache_rdata  input  32  ICache read data.
- fs_discarding  output  1  discard_cnt != 0.

Behaviour:
- State: fs_valid, fs_bus (pc, req, exception), inst_buf[31:0], inst_buf_valid, discard_cnt[CNT_WIDTH-1:0].
- Reset: fs_valid=0, inst_buf_valid=0, discard_cnt=0. Outputs: fs_to_ds_bus.valid=0, fs_allowin=1, fs_discarding=0.
- data_ok is live when icache_data_ok=1 and discard_cnt==0. When discard_cnt>0, data_ok is consumed by the discard logic only.
- Waiting condition: fs_waiting = fs_valid && fs_bus.req && !fs_bus.exception.ex && !inst_buf_valid.
- Ready: fs_ready_go = !fs_waiting || data_ok live.
- Allow-in: fs_allowin = !fs_valid || (fs_ready_go && ds_allowin). This is forced to 1 while flush=1.
- Valid to ID: fs_to_ds_bus.valid = fs_valid && fs_ready_go && !flush.
- Instruction select: inst = inst_buf if inst_buf_valid; else 32'h0 if exception.ex or !req; else icache_rdata. Zero-latency bypass.
- pc and exception pass straight through from fs_bus.
- Advance: when fs_allowin && !flush, fs_valid <= pfs_to_fs_bus.valid, fs_bus is latched, and inst_buf_valid <= 0.
- Buffer: live data_ok while fs_waiting && !ds_allowin sets inst_buf <= icache_rdata and inst_buf_valid <= 1. The stage stays valid until ID accepts.
- Discard: each cycle with icache_data_ok && discard_cnt>0 decrements discard_cnt.
- Flush: fs_valid <= 0 and inst_buf_valid <= 0. discard_cnt <= discard_cnt − (icache_data_ok && discard_cnt>0) + (fs_waiting && !data_ok live) + pfs_outstanding. All terms are evaluated in the same cycle.
- A flush in the same cycle as a live data_ok for the current fetch adds nothing for that fetch, because its response is consumed.
- discard_cnt must never exceed 3. An overflow is an assertion failure, not a wrap.
- New fetches issued after a flush are accepted normally; their data_ok is honoured only once discard_cnt reaches 0 (ordering guarantee).
- Reset asserted mid-wait clears all state. No discard is recorded; the ICache is reset in the same cycle.
- Exception or !req entries need no ICache response and are ready immediately.

Test Plan:
- Normal fetch: pfs valid, req=1, pc=0xBFC00000; data_ok one cycle later with rdata=0x24080001 and ds_allowin=1 -> fs_to_ds_bus.valid=1 that cycle with inst=0x24080001 and pc=0xBFC00000; fs_allowin=1.
- ID stall: data_ok with rdata=0x3C1DBFC0 while ds_allowin=0 for 3 cycles -> inst_buf_valid=1, fs_to_ds_bus.valid=1 held with inst=0x3C1DBFC0, fs_allowin=0; when ds_allowin=1, the stage accepts the next pfs entry.
- Flush during wait: fs waiting on req, pfs_outstanding=1, flush=1 -> discard_cnt=2 and fs_discarding=1. Next two data_ok (0x11111111, 0x22222222) are dropped with fs_to_ds_bus.valid=0. A third data_ok (0x33333333) for new pc=0xBFC00380 is delivered.
- Flush coincident with data_ok: flush=1 and data_ok in the same cycle for the waiting fetch, pfs_outstanding=0 -> discard_cnt stays 0 and fs_to_ds_bus.valid=0.
- Fetch exception: pfs entry with exception.ex=1, exccode=0x04, req=0, pc=0x00000001 -> valid to ID the next cycle with inst=0 and exccode=0x04; data_ok is not awaited.
- Reset mid-wait: reset=1 while waiting with discard_cnt=1 -> next cycle fs_valid=0, discard_cnt=0, fs_allowin=1.
